cam_config_sequencer: RTL and testbench

- Sequences the camera's power-up register configuration over SCCB/I2C.
- Walks a register table (ROM port), issues one write per entry to the existing I2C master via req/ack/done handshake, inserts delays, retries NACKed writes, then waits for VSYNC frames to settle before asserting locked.
- Sits between the top-level balldetector control logic (start/locked/busy) and the I2C master driving i2c_clk/i2c_sda.

---
 rtl/cam_config_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cam_config_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_config_sequencer.sv
// Camera power-up register sequencer: walks a register table, issues
// I2C writes with retry and delays, then waits for VSYNC frames to settle.
module cam_config_sequencer #(
  parameter int IDX_W         = 8,
  parameter int DELAY_UNIT    = 50000,
  parameter int RESET_DELAY   = 100000,
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [15:0]      rom_data,
  output logic             i2c_req,
  output logic [7:0]       i2c_reg,
  output logic [7:0]       i2c_val,
  input  logic             i2c_ack,
  input  logic             i2c_done,
  input  logic             i2c_nack,
  input  logic             vsync,
  output logic             busy,
  output logic             locked,
  output logic             error,
  output logic [IDX_W-1:0] wr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT,
    S_DELAY, S_NEXT, S_SETTLE, S_LOCKED, S_ERROR
  } state_e;

  localparam logic [31:0] RST_LOAD =
    (RESET_DELAY > 0) ? 32'(RESET_DELAY - 1) : 32'd0;

  state_e           state_q;
  logic [IDX_W-1:0] addr_q;
  logic [IDX_W-1:0] wrc_q;
  logic [7:0]       reg_q;
  logic [7:0]       val_q;
  logic             req_q;
  logic             busy_q;
  logic             locked_q;
  logic             error_q;
  logic [31:0]      dly_q;
  logic [7:0]       retry_q;
  logic [7:0]       frame_q;
  logic [2:0]       vs_q;

  logic        vs_rise;
  logic        done_now;
  logic        soft_rst;
  logic        is_term;
  logic        is_dly;
  logic        is_wr;
  logic [31:0] unit_dly;
  logic [31:0] dly_load;

  assign vs_rise  = vs_q[1] & ~vs_q[2];
  // ack and done together in ISSUE are taken as ack followed by done
  assign done_now = i2c_done &
                    ((state_q == S_WAIT) |
                     ((state_q == S_ISSUE) & i2c_ack));
  assign soft_rst = (reg_q == 8'h12) & val_q[7];
  assign is_term  = (rom_data == 16'hFFFF);
  assign is_dly   = (rom_data[15:8] == 8'hFF) & ~is_term;
  assign is_wr    = (rom_data[15:8] != 8'hFF);
  assign unit_dly = 32'(rom_data[7:0]) * 32'(DELAY_UNIT);
  assign dly_load = (unit_dly == 32'd0) ? 32'd0 : unit_dly - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= '0;
    end else begin
      vs_q <= {vs_q[1:0], vsync};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wrc_q    <= '0;
      reg_q    <= '0;
      val_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      dly_q    <= '0;
      retry_q  <= '0;
      frame_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_LOCKED, S_ERROR: begin
          if (start) begin
            state_q  <= S_FETCH;
            addr_q   <= '0;
            wrc_q    <= '0;
            retry_q  <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            is_term: begin
              state_q <= S_SETTLE;
              frame_q <= '0;
            end
            is_dly: begin
              state_q <= S_DELAY;
              dly_q   <= dly_load;
            end
            is_wr: begin
              reg_q   <= rom_data[15:8];
              val_q   <= rom_data[7:0];
              req_q   <= 1'b1;
              state_q <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: begin
          if (i2c_ack) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: ;
        S_DELAY: begin
          if (dly_q == 32'd0) state_q <= S_NEXT;
          else dly_q <= dly_q - 32'd1;
        end
        S_NEXT: begin
          if (addr_q == '1) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            addr_q  <= addr_q + IDX_W'(1);
            state_q <= S_FETCH;
          end
        end
        S_SETTLE: begin
          if (vs_rise) begin
            if (frame_q + 8'd1 >= 8'(SETTLE_FRAMES)) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              frame_q <= frame_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (done_now) begin
        if (!i2c_nack) begin
          wrc_q   <= wrc_q + IDX_W'(1);
          retry_q <= '0;
          if (soft_rst) begin
            state_q <= S_DELAY;
            dly_q   <= RST_LOAD;
          end else begin
            state_q <= S_NEXT;
          end
        end else if (retry_q < 8'(MAX_RETRY)) begin
          retry_q <= retry_q + 8'd1;
          req_q   <= 1'b1;
          state_q <= S_ISSUE;
        end else begin
          state_q <= S_ERROR;
          error_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign rom_addr = addr_q;
  assign i2c_req  = req_q;
  assign i2c_reg  = reg_q;
  assign i2c_val  = val_q;
  assign busy     = busy_q;
  assign locked   = locked_q;
  assign error    = error_q;
  assign wr_count = wrc_q;

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Bench for cam_config_sequencer: ROM and I2C master models,
// table-level reference model, directed and random sequences.
module tb_cam_config_sequencer;

  localparam int IDX_W = 2;
  localparam int DU    = 10;
  localparam int RD    = 20;
  localparam int MR    = 3;
  localparam int SF    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] rom_addr;
  logic [15:0]      rom_data = '0;
  logic             i2c_req;
  logic [7:0]       i2c_reg;
  logic [7:0]       i2c_val;
  logic             i2c_ack = 1'b0;
  logic             i2c_done = 1'b0;
  logic             i2c_nack = 1'b0;
  logic             vsync = 1'b0;
  logic             busy;
  logic             locked;
  logic             error;
  logic [IDX_W-1:0] wr_count;

  always #5 clk = ~clk;

  cam_config_sequencer #(
    .IDX_W(IDX_W), .DELAY_UNIT(DU), .RESET_DELAY(RD),
    .MAX_RETRY(MR), .SETTLE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_req(i2c_req), .i2c_reg(i2c_reg), .i2c_val(i2c_val),
    .i2c_ack(i2c_ack), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .vsync(vsync), .busy(busy), .locked(locked), .error(error),
    .wr_count(wr_count)
  );

  logic [15:0] tbl [4];
  always @(posedge clk) rom_data <= tbl[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;
  logic [15:0] rec[$];
  logic [15:0] exp_q[$];
  int req_cyc[$];
  int done_cyc[$];
  int nack_left = 0;
  int exp_wrc;
  bit exp_lock;
  bit exp_err;
  int start_cyc;
  int addr1_cyc = -1;
  logic [IDX_W-1:0] addr_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rom_addr == IDX_W'(1) && addr_prev != IDX_W'(1) && addr1_cyc < 0)
        addr1_cyc = cyc;
      addr_prev = rom_addr;
    end
  end

  task automatic do_done();
    i2c_done = 1'b1;
    if (nack_left > 0) begin
      i2c_nack = 1'b1;
      nack_left--;
    end
    done_cyc.push_back(cyc);
  endtask

  // I2C master: random ack latency, random done latency (0 = same cycle)
  initial begin
    int st;
    int c1;
    int c2;
    st = 0; c1 = 0; c2 = 0;
    forever begin
      @(negedge clk);
      i2c_ack = 1'b0;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!rst_n) st = 0;
      if (st == 2) begin
        if (c2 == 0) begin
          do_done();
          st = 0;
        end else c2--;
      end else if (st == 0 && i2c_req) begin
        req_cyc.push_back(cyc);
        c1 = $urandom_range(0, 2);
        st = 1;
      end
      if (st == 1) begin
        if (!i2c_req) st = 0;
        else if (c1 == 0) begin
          i2c_ack = 1'b1;
          rec.push_back({i2c_reg, i2c_val});
          c2 = $urandom_range(0, 3);
          st = 2;
          if (c2 == 0) begin
            do_done();
            st = 0;
          end
        end else c1--;
      end
    end
  end

  // Table-level reference: which writes happen, how often, final outcome
  task automatic model(input int nacks);
    int fails;
    bit stop;
    bit wdone;
    exp_q.delete();
    exp_wrc = 0; exp_lock = 0; exp_err = 0; stop = 0;
    for (int i = 0; i < 4 && !stop; i++) begin
      if (tbl[i] == 16'hFFFF) begin
        exp_lock = 1; stop = 1;
      end else if (tbl[i][15:8] != 8'hFF) begin
        fails = 0; wdone = 0;
        while (!wdone) begin
          exp_q.push_back(tbl[i]);
          if (nacks > 0) begin
            nacks--; fails++;
            if (fails > MR) begin
              exp_err = 1; stop = 1; wdone = 1;
            end
          end else begin
            exp_wrc++; wdone = 1;
          end
        end
      end
    end
    if (!stop) exp_err = 1;
  endtask

  task automatic vs_pulse();
    #3 vsync = 1'b1;
    repeat (5) @(negedge clk);
    #3 vsync = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic run(input int nacks, input bit poke);
    int n;
    int k;
    int cnt;
    bit got;
    bit poked;
    model(nacks);
    nack_left = nacks;
    rec.delete(); req_cyc.delete(); done_cyc.delete();
    addr1_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_addr", 32'(rom_addr), 32'd0);
    chk("start_locked", 32'(locked), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    n = 0; poked = 0;
    while (rec.size() < exp_q.size() && n < 5000) begin
      if (poke && !poked && rec.size() == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        poked = 1;
      end else @(negedge clk);
      n++;
    end
    repeat (150) @(negedge clk);
    chk("write_count", 32'(rec.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rec.size(); i++)
      chk($sformatf("write%0d", i), 32'(rec[i]), 32'(exp_q[i]));
    chk("wr_count", 32'(wr_count), 32'(exp_wrc % 4));
    if (exp_lock) begin
      chk("pre_busy", 32'(busy), 32'd1);
      chk("pre_locked", 32'(locked), 32'd0);
      vs_pulse();
      chk("one_frame_locked", 32'(locked), 32'd0);
      #3 vsync = 1'b1;
      got = 0;
      for (k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (locked) begin
          got = 1;
          chk("busy_at_lock", 32'(busy), 32'd0);
        end
      end
      chk("lock_after_frames", 32'(got), 32'd1);
      chk("lock_no_error", 32'(error), 32'd0);
      #3 vsync = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      chk("err_flag", 32'(error), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_locked", 32'(locked), 32'd0);
      cnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (i2c_req) cnt++;
      end
      chk("err_no_req", 32'(cnt), 32'd0);
    end
  endtask

  initial begin
    int gap;
    int n;
    int cnt;
    bit ok;
    tbl = '{16'h0, 16'h0, 16'h0, 16'h0};
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({rom_addr, i2c_req, i2c_reg, i2c_val,
                           busy, locked, error, wr_count}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    tbl = '{16'h1280, 16'h1104, 16'h40D0, 16'hFFFF};
    run(0, 1);
    ok = (req_cyc.size() > 1 && done_cyc.size() > 0);
    gap = ok ? req_cyc[1] - done_cyc[0] : 0;
    chk("soft_reset_gap", 32'(gap >= RD), 32'd1);

    run(0, 0);

    tbl = '{16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run(2, 0);
    run(4, 0);

    tbl = '{16'hFF03, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run(0, 0);
    gap = addr1_cyc - (start_cyc + 1);
    chk("delay_gap", 32'(addr1_cyc >= 0 && gap >= 29 && gap <= 33), 32'd1);

    tbl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run(0, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom % 6)
          0: tbl[i] = 16'hFFFF;
          1: tbl[i] = {8'hFF, 8'($urandom % 4)};
          default: tbl[i] = {8'($urandom % 255), 8'($urandom)};
        endcase
      end
      run(int'($urandom % 6), 0);
    end

    tbl = '{16'h1280, 16'h1104, 16'h40D0, 16'hFFFF};
    nack_left = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!i2c_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_before_rst", 32'(i2c_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({rom_addr, i2c_req, i2c_reg, i2c_val,
                               busy, locked, error, wr_count}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (i2c_req) cnt++;
    end
    chk("no_reissue", 32'(cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    run(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
